clfsr_keystream_gen: RTL

//  Chaotic keystream source feeding the encrypt stage. Couples a Q0.16 logistic map
//  (x' = r*x*(1-x)) with a 16-bit Fibonacci LFSR. Emits one 24-bit {R,G,B} key word
//  per pixel over a valid/ready handshake. Stops after NUM_PIXELS words and pulses done.

---
 rtl/clfsr_keystream_gen_pkg.sv | 39 +++
 rtl/clfsr_keystream_gen_logistic_step.sv | 38 +++
 rtl/clfsr_keystream_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clfsr_keystream_gen_pkg.sv
// rtl/clfsr_keystream_gen_pkg.sv - shared constants, FSM states and helpers for the keystream generator
package clfsr_keystream_gen_pkg;

    // Substitutes for all-zero seeds.
    // A zero map state is a fixed point of the logistic map.
    // A zero LFSR state locks the LFSR.
    localparam logic [15:0] SEED_X_SUB     = 16'h5A5A;
    localparam logic [15:0] SEED_LFSR_SUB  = 16'hACE1;

    // Logistic coefficient r = 3.99 in Q2.14
    localparam logic [15:0] R_COEF_DEFAULT = 16'hFF5C;

    // Fibonacci LFSR feedback taps (x^16 + x^14 + x^13 + x^11 + 1)
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC1 = 2'd1,
        ST_CALC2 = 2'd2,
        ST_VALID = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
    endfunction

    // {R,G,B}: R = x_hi^l_hi, G = x_lo^l_lo, B = R^G
    function automatic logic [23:0] key_word(input logic [15:0] x, input logic [15:0] l);
        logic [7:0] r;
        logic [7:0] g;
        r = x[15:8] ^ l[15:8];
        g = x[7:0]  ^ l[7:0];
        return {r, g, r ^ g};
    endfunction

endpackage

// File: rtl/clfsr_keystream_gen_logistic_step.sv
// rtl/clfsr_keystream_gen_logistic_step.sv - combinational logistic-map datapath (p and xn)
// Ports:
//   x        in  16  current map state, Q0.16
//   p_reg    in  16  registered x*(1-x), Q0.16
//   lfsr_hi  in  15  bits [15:1] of the advanced LFSR, used for the xn==0 fix-up
//   p        out 16  x*(1-x), Q0.16 (<= 0.25)
//   xn       out 16  next map state r*p, Q0.16, never zero
module clfsr_keystream_gen_logistic_step
    import clfsr_keystream_gen_pkg::*;
#(
    parameter logic [15:0] R_COEF = R_COEF_DEFAULT
) (
    input  logic [15:0] x,
    input  logic [15:0] p_reg,
    input  logic [14:0] lfsr_hi,
    output logic [15:0] p,
    output logic [15:0] xn
);

    logic [16:0] omx;
    logic [15:0] xn_raw;

    // 1 - x needs 17 bits because 1.0 = 17'h10000
    assign omx = 17'h10000 - {1'b0, x};

    // x*(1-x) is at most 2^30, so a 32-bit product is exact.
    // Keep bits [31:16].
    assign p = 16'(({16'd0, x} * {15'd0, omx}) >> 16);

    // Q2.14 * Q0.16 -> Q2.30.
    // Bits [29:14] form the Q0.16 result.
    // r < 4 keeps the product below 1.0.
    assign xn_raw = 16'(({16'd0, R_COEF} * {16'd0, p_reg}) >> 14);

    // Forcing bit 0 high keeps the map out of its zero fixed point
    assign xn = (xn_raw == 16'd0) ? {lfsr_hi, 1'b1} : xn_raw;

endmodule

// File: rtl/clfsr_keystream_gen.sv
// rtl/clfsr_keystream_gen.sv - chaotic logistic-map/LFSR keystream source, one {R,G,B} word per pixel
// Ports:
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous reset, active low
//   start      in   1      run request, sampled only in IDLE
//   seed_x     in   16     initial map state (0 -> 16'h5A5A)
//   seed_lfsr  in   16     initial LFSR state (0 -> 16'hACE1)
//   ks_data    out  24     {R,G,B} key word
//   ks_valid   out  1      key word offered
//   ks_ready   in   1      consumer accepts when ks_valid && ks_ready
//   pix_idx    out  CNT_W  index of the offered word
//   busy       out  1      not IDLE
//   done       out  1      one-cycle pulse after the last word is accepted
module clfsr_keystream_gen
    import clfsr_keystream_gen_pkg::*;
#(
    parameter int          NUM_PIXELS   = 65536,
    parameter int          WARMUP_ITERS = 64,
    parameter logic [15:0] R_COEF       = R_COEF_DEFAULT,
    parameter int          CNT_W        = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed_x,
    input  logic [15:0]      seed_lfsr,
    output logic [23:0]      ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [CNT_W-1:0] pix_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] WARM_LIM = CNT_W'(WARMUP_ITERS);

    state_t state;
    state_t state_n;

    logic [15:0]      x;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_n;
    logic [15:0]      p_reg;
    logic [15:0]      p_comb;
    logic [15:0]      xn;
    logic [CNT_W-1:0] warm_cnt;
    logic             warm_done;
    logic             last_word;

    assign lfsr_n = lfsr_next(lfsr);

    // warm_cnt counts up from zero and stops at the limit.
    // An equality test is therefore enough, including when WARMUP_ITERS = 0.
    assign warm_done = (warm_cnt == WARM_LIM);
    assign last_word = (pix_idx == LAST_IDX);
    assign busy      = (state != ST_IDLE);

    clfsr_keystream_gen_logistic_step #(
        .R_COEF (R_COEF)
    ) u_step (
        .x       (x),
        .p_reg   (p_reg),
        .lfsr_hi (lfsr_n[15:1]),
        .p       (p_comb),
        .xn      (xn)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_CALC1;
            ST_CALC1: state_n = ST_CALC2;
            ST_CALC2: state_n = warm_done ? ST_VALID : ST_CALC1;
            ST_VALID: if (ks_ready) state_n = last_word ? ST_IDLE : ST_CALC1;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x        <= 16'd0;
            lfsr     <= 16'd0;
            p_reg    <= 16'd0;
            warm_cnt <= '0;
            pix_idx  <= '0;
            ks_data  <= 24'd0;
            ks_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x        <= (seed_x == 16'd0)    ? SEED_X_SUB    : seed_x;
                        lfsr     <= (seed_lfsr == 16'd0) ? SEED_LFSR_SUB : seed_lfsr;
                        warm_cnt <= '0;
                        pix_idx  <= '0;
                    end
                end
                ST_CALC1: begin
                    p_reg <= p_comb;
                end
                ST_CALC2: begin
                    x    <= xn;
                    lfsr <= lfsr_n;
                    if (!warm_done) begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end else begin
                        ks_data  <= key_word(xn, lfsr_n);
                        ks_valid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (ks_ready) begin
                        ks_valid <= 1'b0;
                        if (last_word) begin
                            done <= 1'b1;
                        end else begin
                            pix_idx <= pix_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
